p_elastic_pipe_reg: RTL and testbench
=====================================

P_ELASTIC_PIPE_REG -- requirements
Module: p_elastic_pipe_reg

Interface
REQ-001 Parameter WIDTH, 32, payload width in bits (>=1).
REQ-002 Parameter SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-003 Parameter CNT_W, 16, stall counter width in bits (>=1).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous kill of all buffered entries.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  block accepts payload this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  downstream payload valid.
REQ-011 out_ready  input  1  downstream accepts payload.
REQ-012 out_data  output  WIDTH  downstream payload, driven directly from the main register.
REQ-013 occupancy  output  2  number of valid entries held (0..2).
REQ-014 stall_count  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 State SHALL be EMPTY, ONE or TWO; occupancy = 0/1/2 respectively; out_valid = (state != EMPTY).
REQ-017 SKID_EN=1: in_ready = (state != TWO), decoded from registered state only; no combinational path from out_ready to in_ready.
REQ-018 SKID_EN=0: state TWO is unreachable; in_ready = !out_valid | out_ready.
REQ-019 EMPTY: in_fire -> ONE, main <= in_data; otherwise stay EMPTY.
REQ-020 ONE: in_fire & out_fire -> ONE, main <= in_data.
REQ-021 ONE: in_fire & !out_ready -> TWO, skid <= in_data, main unchanged (SKID_EN=1 only).
REQ-022 ONE: !in_fire & out_fire -> EMPTY; neither fire -> hold.
REQ-023 TWO: out_fire -> ONE, main <= skid; no out_fire -> hold; in_fire is impossible.
REQ-024 Payloads SHALL leave in strict acceptance order; none dropped or duplicated except by flush.
REQ-025 Latency: an accepted payload appears on out_data/out_valid in the cycle after acceptance when the block was EMPTY.
REQ-026 flush=1 SHALL force state EMPTY next cycle, overriding all fires in that cycle; an in_fire coincident with flush is discarded; main/skid data registers are not cleared.
REQ-027 in_ready and out_valid SHALL keep their normal combinational values during the flush cycle; the flush takes effect at the next edge.
REQ-028 stall_count SHALL increment by 1 each cycle with out_valid & !out_ready and no flush, saturating at 2^CNT_W-1 (no wrap).
REQ-029 stall_count SHALL be cleared only by rst; flush does not affect it.
REQ-030 out_data while out_valid=0 is don't-care to consumers but SHALL equal the last main register value.

Reset
REQ-031 rst SHALL take priority over flush and all handshakes.
REQ-032 After rst: state EMPTY, main = 0, skid = 0, stall_count = 0.
REQ-033 Outputs during and after rst: out_valid=0, occupancy=0, out_data=0, in_ready=1.
REQ-034 rst asserted with state TWO SHALL discard both entries with no output fire in that cycle.

Verification
REQ-035 WIDTH=32, SKID_EN=1, out_ready=1: stream 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, in_ready stays 1, occupancy 1.
REQ-036 out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB, then EMPTY, stall_count = stall cycles elapsed.
REQ-037 State TWO (0xA,0xB) with flush=1 and in_valid=1 in_data=0xC -> next cycle out_valid=0, occupancy 0, 0xC never emerges, stall_count unchanged.
REQ-038 CNT_W=2, out_valid held with out_ready=0 for 6 cycles -> stall_count reads 1,2,3,3,3,3.
REQ-039 SKID_EN=0: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with new in_valid -> in_ready=1, back-to-back transfer, occupancy never 2.
REQ-040 rst pulsed while occupancy 2 and stall_count=5 -> next cycle out_valid=0, out_data=0, in_ready=1, stall_count=0.

Source files
------------

// File: rtl/p_elastic_pipe_reg.sv
// Elastic pipeline register: one main stage plus an optional skid entry, with flush and a
// saturating backpressure-cycle counter.
module p_elastic_pipe_reg #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SKID_EN = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             in_fire, out_fire;

    // rst masks the handshake outputs so nothing fires while reset is held.
    always_comb begin
        out_valid = (state_q != StEmpty) && !rst;
        if (SKID_EN != 0) begin
            in_ready = (state_q != StTwo) || rst;
        end else begin
            in_ready = !out_valid || out_ready || rst;
        end
        unique case (state_q)
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
        if (rst) begin
            occupancy = 2'd0;
        end
    end

    assign out_data    = main_q;
    assign stall_count = stall_q;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StOne;
                    main_d  = in_data;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire && (SKID_EN != 0)) begin
                    state_d = StTwo;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_fire) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush discards everything in flight, including a coincident accept.
        if (flush) begin
            state_d = StEmpty;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_p_elastic_pipe_reg.sv
// Directed bench for p_elastic_pipe_reg: skid, saturating-counter and no-skid variants.
module tb_p_elastic_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;

    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_count;

    logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [7:0]  s_in_data = '0;
    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occupancy;
    logic [1:0]  s_stall_count;

    logic        n_flush = 1'b0, n_in_valid = 1'b0, n_out_ready = 1'b0;
    logic [31:0] n_in_data = '0;
    logic        n_in_ready, n_out_valid;
    logic [31:0] n_out_data;
    logic [1:0]  n_occupancy;
    logic [15:0] n_stall_count;

    always #5 clk = ~clk;

    p_elastic_pipe_reg #(.WIDTH(32), .SKID_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_count(stall_count)
    );

    p_elastic_pipe_reg #(.WIDTH(8), .SKID_EN(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .occupancy(s_occupancy), .stall_count(s_stall_count)
    );

    p_elastic_pipe_reg #(.WIDTH(32), .SKID_EN(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_data(n_out_data), .occupancy(n_occupancy), .stall_count(n_stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_during got v=%b r=%b occ=%0d want v=0 r=1 occ=0",
                     out_valid, in_ready, occupancy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
            stall_count !== 16'h0 || n_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_after got v=%b r=%b d=%h st=%0d nr=%b want 0 1 0 0 1",
                     out_valid, in_ready, out_data, stall_count, n_in_ready);
        end
    endtask

    task automatic test_stream();
        logic [31:0] vals [3] = '{32'h1, 32'h2, 32'h3};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1) begin
                miscompares++;
                $display("FAIL stream_out[%0d] got v=%b d=%h occ=%0d want v=1 d=%h occ=1",
                         i, out_valid, out_data, occupancy, vals[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_count !== 16'd0) begin
            miscompares++;
            $display("FAIL stream_drain got v=%b occ=%0d st=%0d want 0 0 0",
                     out_valid, occupancy, stall_count);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL skid_ready_one got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA ||
            stall_count !== 16'd1) begin
            miscompares++;
            $display("FAIL skid_full got occ=%0d r=%b d=%h st=%0d want 2 0 a 1",
                     occupancy, in_ready, out_data, stall_count);
        end
        tick();
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hA || stall_count !== 16'd2) begin
            miscompares++;
            $display("FAIL skid_first got v=%b d=%h st=%0d want 1 a 2",
                     out_valid, out_data, stall_count);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || occupancy !== 2'd1) begin
            miscompares++;
            $display("FAIL skid_second got v=%b d=%h occ=%0d want 1 b 1",
                     out_valid, out_data, occupancy);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_count !== 16'd2 ||
            out_data !== 32'hB) begin
            miscompares++;
            $display("FAIL skid_empty got v=%b occ=%0d st=%0d d=%h want 0 0 2 b",
                     out_valid, occupancy, stall_count, out_data);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        flush   = 1'b1;
        in_data = 32'hC;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || occupancy !== 2'd2) begin
            miscompares++;
            $display("FAIL flush_cycle got r=%b v=%b occ=%0d want 0 1 2",
                     in_ready, out_valid, occupancy);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_count !== 16'd3) begin
            miscompares++;
            $display("FAIL flush_two got v=%b occ=%0d st=%0d want 0 0 3",
                     out_valid, occupancy, stall_count);
        end
        // Accept coincident with flush from EMPTY must also vanish.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hC;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'hA) begin
            miscompares++;
            $display("FAIL flush_accept got v=%b d=%h want 0 a", out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || stall_count !== 16'd3) begin
            miscompares++;
            $display("FAIL flush_quiet got v=%b st=%0d want 0 3", out_valid, stall_count);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_sat [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 8'h5A;
        tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (s_stall_count !== exp_sat[i]) begin
                miscompares++;
                $display("FAIL sat_count[%0d] got %0d want %0d", i, s_stall_count, exp_sat[i]);
            end
        end
        s_out_ready = 1'b1;
        #1;
        vectors++;
        if (s_out_valid !== 1'b1 || s_out_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL sat_data got v=%b d=%h want 1 5a", s_out_valid, s_out_data);
        end
        tick();
        vectors++;
        if (s_out_valid !== 1'b0 || s_stall_count !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_drain got v=%b st=%0d want 0 3", s_out_valid, s_stall_count);
        end
    endtask

    task automatic test_no_skid();
        n_out_ready = 1'b0;
        n_in_valid  = 1'b1;
        n_in_data   = 32'h11;
        #1;
        vectors++;
        if (n_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL noskid_empty_ready got %b want 1", n_in_ready);
        end
        tick();
        n_in_data = 32'h22;
        #1;
        vectors++;
        if (n_in_ready !== 1'b0 || n_out_valid !== 1'b1 || n_occupancy !== 2'd1) begin
            miscompares++;
            $display("FAIL noskid_block got r=%b v=%b occ=%0d want 0 1 1",
                     n_in_ready, n_out_valid, n_occupancy);
        end
        tick();
        vectors++;
        if (n_out_data !== 32'h11 || n_occupancy !== 2'd1) begin
            miscompares++;
            $display("FAIL noskid_hold got d=%h occ=%0d want 11 1", n_out_data, n_occupancy);
        end
        n_out_ready = 1'b1;
        #1;
        vectors++;
        if (n_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL noskid_release got %b want 1", n_in_ready);
        end
        tick();
        n_in_data = 32'h33;
        #1;
        vectors++;
        if (n_out_data !== 32'h22 || n_occupancy !== 2'd1 || n_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL noskid_b2b1 got d=%h occ=%0d r=%b want 22 1 1",
                     n_out_data, n_occupancy, n_in_ready);
        end
        tick();
        n_in_valid = 1'b0;
        #1;
        vectors++;
        if (n_out_data !== 32'h33 || n_occupancy !== 2'd1) begin
            miscompares++;
            $display("FAIL noskid_b2b2 got d=%h occ=%0d want 33 1", n_out_data, n_occupancy);
        end
        tick();
        vectors++;
        if (n_out_valid !== 1'b0 || n_occupancy !== 2'd0) begin
            miscompares++;
            $display("FAIL noskid_drain got v=%b occ=%0d want 0 0", n_out_valid, n_occupancy);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (stall_count !== 16'd5 || occupancy !== 2'd2) begin
            miscompares++;
            $display("FAIL rstfull_pre got st=%0d occ=%0d want 5 2", stall_count, occupancy);
        end
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            miscompares++;
            $display("FAIL rstfull_during got v=%b r=%b occ=%0d want 0 1 0",
                     out_valid, in_ready, occupancy);
        end
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 ||
            stall_count !== 16'd0 || occupancy !== 2'd0) begin
            miscompares++;
            $display("FAIL rstfull_after got v=%b d=%h r=%b st=%0d occ=%0d want 0 0 1 0 0",
                     out_valid, out_data, in_ready, stall_count, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_saturate();
        test_no_skid();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
